// File: rtl/chroma_pkg.sv
// rtl/chroma_pkg.sv - shared types and widths for the horizontal chroma upsampler
package chroma_pkg;
  localparam int CHROMA_DATA_W = 64;
  localparam int CHROMA_BYTES  = 8;

  typedef logic [7:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    OUT_LO,
    OUT_HI
  } hup_state_e;
endpackage

// File: rtl/nasti_stream_channel.sv
// rtl/nasti_stream_channel.sv - 64-bit stream channel carrying eight chroma samples per beat
interface nasti_stream_channel;
  import chroma_pkg::*;

  logic [CHROMA_DATA_W-1:0]   t_data;
  logic [CHROMA_DATA_W/8-1:0] t_keep;
  logic                       t_last;
  logic                       t_valid;
  logic                       t_ready;

  modport master (output t_data, t_keep, t_last, t_valid, input t_ready);
  modport slave  (input t_data, t_keep, t_last, t_valid, output t_ready);
endinterface

// File: rtl/chroma_h_expand.sv
// rtl/chroma_h_expand.sv - doubles eight samples into sixteen, inserting copies or rounded averages
module chroma_h_expand
  import chroma_pkg::*;
(
  input  logic [CHROMA_DATA_W-1:0] word,
  input  sample_t                  c8,
  input  logic                     interp,
  output logic [CHROMA_DATA_W-1:0] lo,
  output logic [CHROMA_DATA_W-1:0] hi
);
  sample_t    c [CHROMA_BYTES+1];
  logic [8:0] s [CHROMA_BYTES];
  logic [2*CHROMA_DATA_W-1:0] r;

  always_comb begin
    r = '0;
    for (int k = 0; k < CHROMA_BYTES; k++) begin
      c[k] = word[8*k +: 8];
    end
    c[CHROMA_BYTES] = c8;
    for (int k = 0; k < CHROMA_BYTES; k++) begin
      // 9-bit sum keeps the carry so 0xFF+0xFF rounds to 0xFF instead of wrapping
      s[k] = {1'b0, c[k]} + {1'b0, c[k+1]} + 9'd1;
      r[16*k +: 8]     = c[k];
      r[16*k + 8 +: 8] = interp ? s[k][8:1] : c[k];
    end
    lo = r[CHROMA_DATA_W-1:0];
    hi = r[2*CHROMA_DATA_W-1:CHROMA_DATA_W];
  end
endmodule

// File: rtl/yuv422to444_hupsample.sv
// rtl/yuv422to444_hupsample.sv - 4:2:2 to 4:4:4 horizontal chroma upsampler, one src beat to two dst beats
module yuv422to444_hupsample
  import chroma_pkg::*;
#(
  parameter int LINE_WORDS = 45,
  parameter bit INTERP     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  nasti_stream_channel.slave   src,
  nasti_stream_channel.master  dst,
  output logic                 err
);
  localparam int COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

  hup_state_e state, state_n;
  logic [CHROMA_DATA_W-1:0] h, h_n, p, p_n, lo, hi;
  logic h_end, h_end_n, h_last, h_last_n;
  logic p_end, p_end_n, p_last, p_last_n, pv, pv_n;
  logic err_n, ready_q, ready_n;
  sample_t c8, c8_n;
  logic [COL_W-1:0] col, col_n;
  logic take, full, beat_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      h       <= '0;
      p       <= '0;
      h_end   <= 1'b0;
      h_last  <= 1'b0;
      p_end   <= 1'b0;
      p_last  <= 1'b0;
      pv      <= 1'b0;
      c8      <= '0;
      col     <= '0;
      err     <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      h       <= h_n;
      p       <= p_n;
      h_end   <= h_end_n;
      h_last  <= h_last_n;
      p_end   <= p_end_n;
      p_last  <= p_last_n;
      pv      <= pv_n;
      c8      <= c8_n;
      col     <= col_n;
      err     <= err_n;
      ready_q <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    h_n      = h;
    p_n      = p;
    h_end_n  = h_end;
    h_last_n = h_last;
    p_end_n  = p_end;
    p_last_n = p_last;
    pv_n     = pv;
    c8_n     = c8;
    col_n    = col;
    err_n    = err;
    take     = src.t_valid && ready_q;
    full     = (src.t_keep == 8'hff);
    beat_end = full && ((col == LAST_COL) || src.t_last);

    if (take) begin
      if (!full) begin
        err_n = 1'b1;
        if (src.t_last) col_n = '0;
      end else begin
        col_n = beat_end ? '0 : col + 1'b1;
      end
    end

    case (state)
      EMPTY: begin
        if (take && full) begin
          h_n      = src.t_data;
          h_end_n  = beat_end;
          h_last_n = src.t_last;
          state_n  = (INTERP && !beat_end) ? HELD : OUT_LO;
        end
      end
      HELD: begin
        if (take && full) begin
          p_n      = src.t_data;
          p_end_n  = beat_end;
          p_last_n = src.t_last;
          pv_n     = 1'b1;
          c8_n     = src.t_data[7:0];
          state_n  = OUT_LO;
        end else if (take && src.t_last) begin
          // a discarded closing beat still ends the frame: flush H with edge replicate
          h_end_n  = 1'b1;
          h_last_n = 1'b1;
          state_n  = OUT_LO;
        end
      end
      OUT_LO: begin
        if (dst.t_ready) state_n = OUT_HI;
      end
      OUT_HI: begin
        if (dst.t_ready) begin
          if (pv) begin
            h_n      = p;
            h_end_n  = p_end;
            h_last_n = p_last;
            pv_n     = 1'b0;
            state_n  = (p_end || !INTERP) ? OUT_LO : HELD;
          end else begin
            state_n  = EMPTY;
          end
        end
      end
      default: state_n = EMPTY;
    endcase

    ready_n = (state_n == EMPTY) || (state_n == HELD);
  end

  chroma_h_expand u_expand (
    .word   (h),
    .c8     (h_end ? h[63:56] : c8),
    .interp (INTERP),
    .lo     (lo),
    .hi     (hi)
  );

  assign src.t_ready = ready_q;
  assign dst.t_valid = (state == OUT_LO) || (state == OUT_HI);
  assign dst.t_keep  = dst.t_valid ? 8'hff : 8'h00;
  assign dst.t_last  = (state == OUT_HI) && h_last;
  assign dst.t_data  = (state == OUT_LO) ? lo : ((state == OUT_HI) ? hi : '0);
endmodule

// File: tb/tb_yuv422to444_hupsample.sv
// tb/tb_yuv422to444_hupsample.sv - self-checking bench for the horizontal chroma upsampler
module tb_yuv422to444_hupsample;
  import chroma_pkg::*;

  typedef struct {
    logic [63:0] word;
    logic [7:0]  c8;
    logic        interp;
    logic [63:0] lo;
    logic [63:0] hi;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nasti_stream_channel a_src ();
  nasti_stream_channel a_dst ();
  nasti_stream_channel b_src ();
  nasti_stream_channel b_dst ();
  logic a_err, b_err;

  yuv422to444_hupsample #(.LINE_WORDS(45), .INTERP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .src(a_src), .dst(a_dst), .err(a_err));
  yuv422to444_hupsample #(.LINE_WORDS(45), .INTERP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .src(b_src), .dst(b_dst), .err(b_err));

  logic [63:0] x_word, x_lo, x_hi;
  sample_t     x_c8;
  logic        x_interp;
  chroma_h_expand u_x (.word(x_word), .c8(x_c8), .interp(x_interp), .lo(x_lo), .hi(x_hi));

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;
  vec_t tbl [6];
  int n_checks  = 0;
  int n_fail    = 0;
  int a_out_cnt = 0;
  int a_mode    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] expand_ref(input logic [63:0] w, input logic [7:0] nxt,
                                              input bit interp);
    logic [7:0]   c [9];
    logic [8:0]   s;
    logic [127:0] r;
    for (int k = 0; k < 8; k++) c[k] = w[8*k +: 8];
    c[8] = nxt;
    for (int k = 0; k < 8; k++) begin
      s = {1'b0, c[k]} + {1'b0, c[k+1]} + 9'd1;
      r[16*k +: 8]     = c[k];
      r[16*k + 8 +: 8] = interp ? s[8:1] : c[k];
    end
    return r;
  endfunction

  // dst ready pattern for dut_a: 0 always, 1 random, 2 stalled, 3 one-cycle pulse
  always begin
    @(posedge clk);
    #2;
    case (a_mode)
      0: a_dst.t_ready = 1'b1;
      1: a_dst.t_ready = 1'($urandom_range(0, 1));
      3: begin a_dst.t_ready = 1'b1; a_mode = 2; end
      default: a_dst.t_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && a_dst.t_valid) begin
      chk("a_src_ready_while_out", 64'(a_src.t_ready), 64'd0);
      chk("a_keep", 64'(a_dst.t_keep), 64'hff);
      if (a_dst.t_ready) begin
        a_out_cnt++;
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_beat: got %h, expected no beat", a_dst.t_data);
        end else begin
          ea = exp_a.pop_front();
          chk("a_data", a_dst.t_data, ea.data);
          chk("a_last", 64'(a_dst.t_last), 64'(ea.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_dst.t_valid && b_dst.t_ready) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_beat: got %h, expected no beat", b_dst.t_data);
      end else begin
        eb = exp_b.pop_front();
        chk("b_data", b_dst.t_data, eb.data);
        chk("b_last", 64'(b_dst.t_last), 64'(eb.last));
      end
    end
  end

  task automatic send_a(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    a_src.t_data = d; a_src.t_keep = k; a_src.t_last = l; a_src.t_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!a_src.t_ready && n < 300);
    chk("a_src_accept", 64'(a_src.t_ready), 64'd1);
    @(posedge clk);
    #1;
    a_src.t_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input logic l);
    int n = 0;
    b_src.t_data = d; b_src.t_keep = 8'hff; b_src.t_last = l; b_src.t_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!b_src.t_ready && n < 300);
    chk("b_src_accept", 64'(b_src.t_ready), 64'd1);
    @(posedge clk);
    #1;
    b_src.t_valid = 1'b0;
  endtask

  task automatic push_a(input logic [63:0] w, input logic [7:0] nxt, input logic last);
    logic [127:0] r;
    r = expand_ref(w, nxt, 1'b1);
    exp_a.push_back('{data: r[63:0], last: 1'b0});
    exp_a.push_back('{data: r[127:64], last: last});
  endtask

  task automatic send_line_a(input int n, input int bad_pos, input logic last_end);
    logic [63:0] beats [64];
    logic [7:0]  nxt;
    for (int i = 0; i < n; i++) beats[i] = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      if (i == bad_pos) send_a({$urandom, $urandom}, 8'h0f, 1'b0);
      nxt = (i == n - 1) ? beats[i][63:56] : beats[i+1][7:0];
      push_a(beats[i], nxt, last_end && (i == n - 1));
      send_a(beats[i], 8'hff, last_end && (i == n - 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", 64'(exp_a.size()), 64'd0);
    chk("drain_b", 64'(exp_b.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0]  y0, y1, d0;
    logic [127:0] r;
    tbl[0] = '{64'h0706050403020100, 8'h07, 1'b0, 64'h0303020201010000, 64'h0707060605050404};
    tbl[1] = '{64'h0E0C0A0806040200, 8'h10, 1'b1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
    tbl[2] = '{64'h1E1C1A1816141210, 8'h1E, 1'b1, 64'h1716151413121110, 64'h1E1E1D1C1B1A1918};
    tbl[3] = '{64'h00000000000000FF, 8'h00, 1'b1, 64'h00000000000080FF, 64'h0000000000000000};
    tbl[4] = '{64'h000000000000FFFF, 8'h00, 1'b1, 64'h0000000080FFFFFF, 64'h0000000000000000};
    tbl[5] = '{64'hFF00000000000000, 8'hFF, 1'b1, 64'h0000000000000000, 64'hFFFF800000000000};

    a_src.t_valid = 1'b0; a_src.t_data = '0; a_src.t_keep = '0; a_src.t_last = 1'b0;
    b_src.t_valid = 1'b0; b_src.t_data = '0; b_src.t_keep = '0; b_src.t_last = 1'b0;
    b_dst.t_ready = 1'b1;

    #12;
    chk("rst_src_ready", 64'(a_src.t_ready), 64'd0);
    chk("rst_dst_valid", 64'(a_dst.t_valid), 64'd0);
    chk("rst_dst_last", 64'(a_dst.t_last), 64'd0);
    chk("rst_dst_keep", 64'(a_dst.t_keep), 64'd0);
    chk("rst_dst_data", a_dst.t_data, 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_b_dst_valid", 64'(b_dst.t_valid), 64'd0);

    for (int i = 0; i < 6; i++) begin
      x_word = tbl[i].word; x_c8 = tbl[i].c8; x_interp = tbl[i].interp;
      #1;
      chk($sformatf("expand_lo[%0d]", i), x_lo, tbl[i].lo);
      chk($sformatf("expand_hi[%0d]", i), x_hi, tbl[i].hi);
    end

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_a_src_ready", 64'(a_src.t_ready), 64'd1);
    chk("post_rst_b_src_ready", 64'(b_src.t_ready), 64'd1);

    // duplication mode, single-beat frame
    exp_b.push_back('{data: 64'h0303020201010000, last: 1'b0});
    exp_b.push_back('{data: 64'h0707060605050404, last: 1'b1});
    send_b(64'h0706050403020100, 1'b1);
    chk("b_latency_one_cycle", 64'(b_dst.t_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      y0 = {$urandom, $urandom};
      r  = expand_ref(y0, 8'h00, 1'b0);
      exp_b.push_back('{data: r[63:0], last: 1'b0});
      exp_b.push_back('{data: r[127:64], last: (i == 3)});
      send_b(y0, i == 3);
    end
    drain();

    // interpolation with lookahead and edge replicate on the closing beat
    exp_a.push_back('{data: 64'h0706050403020100, last: 1'b0});
    exp_a.push_back('{data: 64'h0F0E0D0C0B0A0908, last: 1'b0});
    send_a(64'h0E0C0A0806040200, 8'hff, 1'b0);
    chk("a_waits_for_next_beat", 64'(a_dst.t_valid), 64'd0);
    exp_a.push_back('{data: 64'h1716151413121110, last: 1'b0});
    exp_a.push_back('{data: 64'h1E1E1D1C1B1A1918, last: 1'b1});
    send_a(64'h1E1C1A1816141210, 8'hff, 1'b1);
    chk("a_valid_after_next_beat", 64'(a_dst.t_valid), 64'd1);
    drain();
    chk("a_err_clean", 64'(a_err), 64'd0);

    // partial-keep beat mid-line: dropped without moving the line position
    send_line_a(45, 20, 1'b0);
    chk("a_err_set", 64'(a_err), 64'd1);
    send_line_a(3, -1, 1'b1);
    drain();
    chk("a_err_sticky", 64'(a_err), 64'd1);

    // three full lines under random backpressure
    a_out_cnt = 0;
    a_mode = 1;
    send_line_a(45, -1, 1'b0);
    send_line_a(45, -1, 1'b0);
    send_line_a(45, -1, 1'b1);
    drain();
    a_mode = 0;
    chk("a_out_beats_3_lines", 64'(a_out_cnt), 64'd270);

    // reset while stalled in the high beat
    a_mode = 2;
    y0 = {$urandom, $urandom};
    y1 = {$urandom, $urandom};
    push_a(y0, y1[7:0], 1'b0);
    send_a(y0, 8'hff, 1'b0);
    push_a(y1, y1[63:56], 1'b1);
    send_a(y1, 8'hff, 1'b1);
    chk("a_stall_valid", 64'(a_dst.t_valid), 64'd1);
    d0 = a_dst.t_data;
    repeat (3) @(negedge clk);
    chk("a_hold_stable", a_dst.t_data, d0);
    a_mode = 3;
    @(posedge clk);
    @(posedge clk);
    #3;
    r = expand_ref(y0, y1[7:0], 1'b1);
    chk("a_stall_out_hi_valid", 64'(a_dst.t_valid), 64'd1);
    chk("a_stall_out_hi_data", a_dst.t_data, r[127:64]);
    rst = 1'b1;
    #1;
    chk("arst_dst_valid", 64'(a_dst.t_valid), 64'd0);
    chk("arst_dst_data", a_dst.t_data, 64'd0);
    chk("arst_dst_keep", 64'(a_dst.t_keep), 64'd0);
    chk("arst_dst_last", 64'(a_dst.t_last), 64'd0);
    chk("arst_src_ready", 64'(a_src.t_ready), 64'd0);
    chk("arst_err", 64'(a_err), 64'd0);
    exp_a.delete();
    a_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_line_a(2, -1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
